// File: rtl/discrete_meter_pkg.sv
// Shared types and helpers for the discrete-oscillator measurement blocks.
// Holds the meter state encoding and a width-generic saturating increment.
package discrete_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } meter_state_e;

    // Increment val, clamping at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_v;
        if (width >= 32'd32) begin
            max_v = 32'hFFFF_FFFF;
        end else begin
            max_v = (32'd1 << width) - 32'd1;
        end
        if (val >= max_v) begin
            return max_v;
        end else begin
            return val + 32'd1;
        end
    endfunction

endpackage

// File: rtl/square_wave_period_meter.sv
// Measures high time, low time and rising-to-rising period of a 1-bit square
// wave in audio samples, and flags a source that has stopped toggling.
module square_wave_period_meter
    import discrete_meter_pkg::*;
#(
    parameter int COUNT_WIDTH = 16,
    parameter int TIMEOUT     = 48000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   audio_clk_en,
    input  logic                   in,
    output logic [COUNT_WIDTH-1:0] high_count,
    output logic [COUNT_WIDTH-1:0] low_count,
    output logic [COUNT_WIDTH:0]   period,
    output logic                   valid,
    output logic                   stalled,
    output logic                   level
);

    localparam logic [COUNT_WIDTH-1:0] RUN_ONE    = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH:0]   TIMEOUT_V  = (COUNT_WIDTH+1)'(TIMEOUT);
    localparam logic                   TIMEOUT_EN = (TIMEOUT > 0);

    meter_state_e            state_q, state_d;
    logic                    level_q, level_d;
    logic [COUNT_WIDTH-1:0]  run_q, run_d;
    logic [COUNT_WIDTH-1:0]  pend_high_q, pend_high_d;
    logic                    have_high_q, have_high_d;
    logic [COUNT_WIDTH-1:0]  high_q, high_d;
    logic [COUNT_WIDTH-1:0]  low_q, low_d;
    logic [COUNT_WIDTH:0]    period_q, period_d;
    logic                    valid_q, valid_d;
    logic                    stalled_q, stalled_d;

    logic                    edge_s;
    logic [COUNT_WIDTH:0]    run_plus_s;
    logic                    timeout_hit_s;
    logic [COUNT_WIDTH-1:0]  run_inc_s;

    assign edge_s        = (in != level_q);
    assign run_plus_s    = {1'b0, run_q} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    assign timeout_hit_s = TIMEOUT_EN && (run_plus_s == TIMEOUT_V);
    assign run_inc_s     = COUNT_WIDTH'(sat_inc(32'(run_q), COUNT_WIDTH));

    // Next-state and measurement update, evaluated only on sample strobes.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        run_d       = run_q;
        pend_high_d = pend_high_q;
        have_high_d = have_high_q;
        high_d      = high_q;
        low_d       = low_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        stalled_d   = stalled_q;

        if (audio_clk_en) begin
            level_d = in;
            if (state_q == IDLE) begin
                run_d   = RUN_ONE;
                state_d = SYNC;
            end else if (edge_s) begin
                // The run just ended is run_q; the current sample starts a new one.
                run_d = RUN_ONE;
                case (state_q)
                    SYNC: begin
                        if (in) begin
                            state_d = HIGH;
                        end else begin
                            state_d     = LOW;
                            have_high_d = 1'b0;
                        end
                    end
                    HIGH: begin
                        if (!in) begin
                            pend_high_d = run_q;
                            have_high_d = 1'b1;
                            state_d     = LOW;
                        end else begin
                            state_d = HIGH;
                        end
                    end
                    LOW: begin
                        if (in) begin
                            if (have_high_q) begin
                                high_d    = pend_high_q;
                                low_d     = run_q;
                                period_d  = {1'b0, pend_high_q} + {1'b0, run_q};
                                valid_d   = 1'b1;
                                stalled_d = 1'b0;
                            end else begin
                                valid_d = 1'b0;
                            end
                            state_d = HIGH;
                        end else begin
                            state_d = LOW;
                        end
                    end
                    default: begin
                        state_d = SYNC;
                    end
                endcase
            end else begin
                run_d = run_inc_s;
                if (timeout_hit_s) begin
                    stalled_d   = 1'b1;
                    have_high_d = 1'b0;
                    state_d     = SYNC;
                end else begin
                    stalled_d = stalled_q;
                end
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            level_q     <= 1'b0;
            run_q       <= '0;
            pend_high_q <= '0;
            have_high_q <= 1'b0;
            high_q      <= '0;
            low_q       <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            stalled_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            run_q       <= run_d;
            pend_high_q <= pend_high_d;
            have_high_q <= have_high_d;
            high_q      <= high_d;
            low_q       <= low_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            stalled_q   <= stalled_d;
        end
    end

    assign high_count = high_q;
    assign low_count  = low_q;
    assign period     = period_q;
    assign valid      = valid_q;
    assign stalled    = stalled_q;
    assign level      = level_q;

endmodule

// File: tb/tb_square_wave_period_meter.sv
// Self-checking bench: two meter instances (16-bit/timeout 100 and 4-bit/no
// timeout) driven identically and compared every cycle to an edge-list model.
module tb_square_wave_period_meter;

    localparam int CW_A = 16;
    localparam int TO_A = 100;
    localparam int CW_B = 4;
    localparam int TO_B = 0;

    logic clk = 1'b0;
    logic reset_n;
    logic en;
    logic din;

    logic [CW_A-1:0] a_high, a_low;
    logic [CW_A:0]   a_per;
    logic            a_valid, a_stalled, a_level;
    logic [CW_B-1:0] b_high, b_low;
    logic [CW_B:0]   b_per;
    logic            b_valid, b_stalled, b_level;

    always #5 clk = ~clk;

    square_wave_period_meter #(.COUNT_WIDTH(CW_A), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .reset_n(reset_n), .audio_clk_en(en), .in(din),
        .high_count(a_high), .low_count(a_low), .period(a_per),
        .valid(a_valid), .stalled(a_stalled), .level(a_level)
    );

    square_wave_period_meter #(.COUNT_WIDTH(CW_B), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .audio_clk_en(en), .in(din),
        .high_count(b_high), .low_count(b_low), .period(b_per),
        .valid(b_valid), .stalled(b_stalled), .level(b_level)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vcount = 0;
    int last_v = 0;
    int prev_v = 0;

    // Reference model: tracks samples since the last edge and edges since sync.
    int m_cw[2];
    int m_to[2];
    bit m_started[2];
    int m_lvl[2], m_len[2], m_edges[2], m_last_high[2];
    int m_hi[2], m_lo[2], m_per[2], m_valid[2], m_stall[2];

    typedef struct {
        int div;
        int hi;
        int lo;
        int exp_hi;
        int exp_lo;
        int exp_per;
    } row_t;

    row_t rows[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int satv(input int v, input int cw);
        int mx;
        mx = (1 << cw) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_started[i] = 1'b0;
            m_lvl[i] = 0; m_len[i] = 0; m_edges[i] = 0; m_last_high[i] = 0;
            m_hi[i] = 0; m_lo[i] = 0; m_per[i] = 0; m_valid[i] = 0; m_stall[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit e, input bit v);
        m_valid[i] = 0;
        if (e) begin
            if (!m_started[i]) begin
                m_started[i] = 1'b1;
                m_len[i] = 1;
                m_edges[i] = 0;
            end else if (v != m_lvl[i]) begin
                m_edges[i]++;
                if (v) begin
                    // A rising edge completes a period once a whole high and low were seen.
                    if (m_edges[i] >= 3) begin
                        m_hi[i]    = satv(m_last_high[i], m_cw[i]);
                        m_lo[i]    = satv(m_len[i], m_cw[i]);
                        m_per[i]   = m_hi[i] + m_lo[i];
                        m_valid[i] = 1;
                        m_stall[i] = 0;
                    end
                end else begin
                    m_last_high[i] = m_len[i];
                end
                m_len[i] = 1;
            end else begin
                m_len[i]++;
                if (m_to[i] > 0 && m_len[i] == m_to[i]) begin
                    m_stall[i] = 1;
                    m_edges[i] = 0;
                end
            end
            m_lvl[i] = v;
        end
    endtask

    task automatic compare_all();
        chk("A high_count", a_high, m_hi[0]);
        chk("A low_count", a_low, m_lo[0]);
        chk("A period", a_per, m_per[0]);
        chk("A valid", a_valid, m_valid[0]);
        chk("A stalled", a_stalled, m_stall[0]);
        chk("A level", a_level, m_lvl[0]);
        chk("B high_count", b_high, m_hi[1]);
        chk("B low_count", b_low, m_lo[1]);
        chk("B period", b_per, m_per[1]);
        chk("B valid", b_valid, m_valid[1]);
        chk("B stalled", b_stalled, m_stall[1]);
        chk("B level", b_level, m_lvl[1]);
    endtask

    // One clock: drive inputs, let the edge happen, then check #1 after it.
    task automatic tick(input bit e, input bit v);
        en  = e;
        din = v;
        @(posedge clk);
        #1;
        cyc++;
        if (!reset_n) begin
            model_reset();
        end else begin
            model_step(0, e, v);
            model_step(1, e, v);
        end
        compare_all();
        if (a_valid === 1'b1) begin
            prev_v = last_v;
            last_v = cyc;
            vcount++;
        end
    endtask

    // n enabled samples at value v, with the strobe high every div-th clock.
    task automatic hold(input int n, input bit v, input int div);
        for (int s = 0; s < n; s++) begin
            for (int k = 0; k < div; k++) begin
                tick(k == div - 1, v);
            end
        end
    endtask

    // n enabled samples at value v with an irregular strobe.
    task automatic hold_rand(input int n, input bit v);
        int got;
        got = 0;
        for (int g = 0; g < 8 * n + 8 && got < n; g++) begin
            if ($urandom_range(0, 3) != 0) begin
                tick(1'b1, v);
                got++;
            end else begin
                tick(1'b0, v);
            end
        end
    endtask

    initial begin
        m_cw[0] = CW_A; m_to[0] = TO_A;
        m_cw[1] = CW_B; m_to[1] = TO_B;
        rows[0] = '{div: 1, hi: 3, lo: 5, exp_hi: 3,  exp_lo: 5, exp_per: 8};
        rows[1] = '{div: 4, hi: 3, lo: 5, exp_hi: 3,  exp_lo: 5, exp_per: 8};
        rows[2] = '{div: 1, hi: 1, lo: 1, exp_hi: 1,  exp_lo: 1, exp_per: 2};
        rows[3] = '{div: 2, hi: 7, lo: 2, exp_hi: 7,  exp_lo: 2, exp_per: 9};
        rows[4] = '{div: 1, hi: 20, lo: 2, exp_hi: 20, exp_lo: 2, exp_per: 22};

        reset_n = 1'b0;
        en      = 1'b0;
        din     = 1'b0;
        model_reset();

        // Reset held with the input toggling: everything stays zero.
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, i[0]);
        end
        chk("reset A high_count", a_high, 32'd0);
        chk("reset A period", a_per, 32'd0);
        chk("reset B valid", b_valid, 32'd0);
        reset_n = 1'b1;

        // Starting high: the first high and first low are partial/unpaired.
        vcount = 0;
        hold(3, 1'b1, 1);
        hold(5, 1'b0, 1);
        hold(3, 1'b1, 1);
        hold(5, 1'b0, 1);
        chk("no early valid", vcount, 32'd0);
        hold(1, 1'b1, 1);
        chk("first valid", vcount, 32'd1);
        chk("first high", a_high, 32'd3);
        chk("first low", a_low, 32'd5);
        chk("first period", a_per, 32'd8);
        hold(2, 1'b1, 1);
        hold(5, 1'b0, 1);

        // Repeating patterns at several strobe rates.
        for (int r = 0; r < 5; r++) begin
            vcount = 0;
            for (int p = 0; p < 5; p++) begin
                hold(rows[r].hi, 1'b1, rows[r].div);
                hold(rows[r].lo, 1'b0, rows[r].div);
            end
            chk("row valid count", 32'(vcount >= 2), 32'd1);
            chk("row high", a_high, rows[r].exp_hi);
            chk("row low", a_low, rows[r].exp_lo);
            chk("row period", a_per, rows[r].exp_per);
            chk("row spacing", last_v - prev_v, rows[r].div * (rows[r].hi + rows[r].lo));
            chk("row stalled", a_stalled, 32'd0);
        end
        chk("sat B high", b_high, 32'd15);
        chk("sat B low", b_low, 32'd2);
        chk("sat B period", b_per, 32'd17);
        chk("sat B stalled", b_stalled, 32'd0);

        // Stall: hold high after a valid period; 100th high sample trips it.
        for (int r = 0; r < 3; r++) begin
            hold(3, 1'b1, 1);
            hold(5, 1'b0, 1);
        end
        hold(99, 1'b1, 1);
        chk("pre-stall", a_stalled, 32'd0);
        hold(1, 1'b1, 1);
        chk("stalled", a_stalled, 32'd1);
        chk("stall hold high", a_high, 32'd3);
        chk("stall hold low", a_low, 32'd5);
        chk("stall hold period", a_per, 32'd8);
        hold(5, 1'b0, 1);
        hold(3, 1'b1, 1);
        chk("stall persists", a_stalled, 32'd1);
        hold(5, 1'b0, 1);
        hold(1, 1'b1, 1);
        chk("stall cleared", a_stalled, 32'd0);
        chk("resume valid", a_valid, 32'd1);
        chk("resume high", a_high, 32'd3);
        chk("resume low", a_low, 32'd5);
        chk("resume period", a_per, 32'd8);
        hold(2, 1'b1, 1);

        // Asynchronous reset in the middle of a low phase.
        hold(2, 1'b0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async A high", a_high, 32'd0);
        chk("async A low", a_low, 32'd0);
        chk("async A period", a_per, 32'd0);
        chk("async A level", a_level, 32'd0);
        chk("async B period", b_per, 32'd0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        reset_n = 1'b1;
        vcount = 0;
        hold(2, 1'b0, 1);
        hold(3, 1'b1, 1);
        hold(5, 1'b0, 1);
        chk("post-reset no valid", vcount, 32'd0);
        hold(1, 1'b1, 1);
        chk("post-reset valid", vcount, 32'd1);
        chk("post-reset high", a_high, 32'd3);
        chk("post-reset low", a_low, 32'd5);
        chk("post-reset period", a_per, 32'd8);
        hold(2, 1'b1, 1);

        // Random phases and strobes, including occasional stalls.
        for (int p = 0; p < 40; p++) begin
            int len;
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(95, 130) : $urandom_range(1, 24);
            hold_rand(len, p[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/square_wave_period_meter.md
Name: square_wave_period_meter

Overview:
- Consumes a 1-bit square wave and measures it, so it sits at the opposite end of a 1-bit square-wave link from a square-wave oscillator model.
- Samples the input on each audio_clk_en strobe and measures the high time, low time and full period in audio samples.
- Reports a one-cycle valid pulse per completed period and flags a stalled (non-oscillating) source.
- Used to check discrete-oscillator models in-system and to drive pitch-dependent logic.

Parameters:
- COUNT_WIDTH, 16: width of the high/low run counters; the period output is COUNT_WIDTH+1 bits.
- TIMEOUT, 48000: number of enabled samples without an edge before the source is declared stalled. 0 disables the timeout. Must be ≤ 2^COUNT_WIDTH-1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- audio_clk_en  in  1  sample strobe; the input is evaluated only on cycles where this is high
- in  in  1  square-wave input, synchronous to clk
- high_count  out  COUNT_WIDTH  samples the input was high in the last complete period
- low_count  out  COUNT_WIDTH  samples the input was low in the last complete period
- period  out  COUNT_WIDTH+1  high_count + low_count
- valid  out  1  one-clk pulse when the three measurement outputs update
- stalled  out  1  level; high while no edge has occurred for TIMEOUT samples
- level  out  1  last sampled input value

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n).
- Reset values: every output is 0; state is IDLE; run=0; pend_high=0.
- Reset mid-operation clears everything immediately, and any partial measurement is discarded.
- When audio_clk_en=0, no state changes, except that valid is driven to 0.
- Edge definition, on an enabled cycle: edge = (in != level). level <= in on every enabled cycle.
- Run counter:
  - On an edge, run <= 1; the new sample is the first sample of the new level.
  - Otherwise run <= run+1, saturating at 2^COUNT_WIDTH-1.
  - The completed run length at an edge is the value of run before the update.
- State machine (states in a shared enum):
  - IDLE: on the first enabled sample, load level <= in, set run <= 1, go to SYNC. No edge is detected on this sample.
  - SYNC: waits for an edge; the partial run is discarded. A rising edge goes to HIGH; a falling edge goes to LOW with have_high=0.
  - HIGH: a falling edge sets pend_high <= run, have_high <= 1, and goes to LOW.
  - LOW, on a rising edge:
    - If have_high: high_count <= pend_high, low_count <= run, period <= pend_high + run (zero-extended, no overflow), valid pulses for 1 clk, stalled <= 0.
    - Always go to HIGH.
- Latency: valid and the outputs are registered and change on the clk edge at which the enabled rising-edge sample is taken. Outputs are readable in the cycle valid is high and hold until the next update.
- Timeout (TIMEOUT>0):
  - Trigger: in SYNC, HIGH or LOW, on an enabled non-edge cycle where run+1 == TIMEOUT.
  - Effect: stalled <= 1, have_high <= 0, next state SYNC. The measurement outputs hold their last values.
  - stalled clears only on the next valid.
- The first valid after reset or after a stall requires a full low phase, a full high phase, then a rising edge. Rising-to-rising periods only.
- A simultaneous edge and timeout threshold cannot occur; an edge always resets run.
- Saturated runs are reported saturated; period sums the saturated values.

Decomposition:
- Package discrete_meter_pkg: state enum (IDLE, SYNC, HIGH, LOW) and a saturating-increment function parameterised by width.
- No sub-module required; single module of roughly 150 lines.

Test Plan:
1. Reset: hold reset_n=0 with in toggling → all outputs 0. Release reset → first valid only after a full low phase, a full high phase and a rising edge.
2. audio_clk_en=1 every clk; in = 3 high, 5 low, repeating → valid every 8 clks with high_count=3, low_count=5, period=8, stalled=0.
3. audio_clk_en=1 every 4th clk, same pattern → identical values; valid pulses are 32 clks apart and exactly 1 clk wide.
4. TIMEOUT=100; in held at 1 after a valid period → stalled=1 after the 100th high sample while outputs hold 3/5/8. Resume the 3/5 pattern → stalled stays 1 until the next valid (a full low+high phase plus rising edge after resume), then stalled=0 with 3/5/8.
5. COUNT_WIDTH=4, TIMEOUT=0; in = 20 high, 2 low, repeating → high_count=15 (saturated), low_count=2, period=17, stalled never asserts.
6. Pull reset_n low asynchronously mid-LOW phase of the 3/5 pattern → outputs 0 immediately. After release, no valid until a full low phase, a full high phase and a rising edge complete; then 3/5/8.
